imem_boot_loader: RTL and testbench

- Sits directly upstream of the single-cycle RISC-V core.
- Receives a program image as a byte stream (valid/ready) from a host-side UART receiver and assembles little-endian 32-bit words.
- Writes each word into the core's instruction memory through a dedicated write port and verifies an image checksum.
- Holds the core in reset until a valid image is loaded, then releases it.

---
 rtl/imem_boot_loader.sv | 79 +++++++
 tb/tb_imem_boot_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed, checksummed byte stream into instruction memory and releases core reset
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Rx_Valid,
  input  logic [7:0]            i_Rx_Data,
  output logic                  o_Rx_Ready,
  output logic                  o_IMem_WE,
  output logic [ADDR_WIDTH-1:0] o_IMem_Addr,
  output logic [31:0]           o_IMem_WData,
  output logic                  o_Core_Reset,
  output logic                  o_Done,
  output logic                  o_Error,
  output logic [ADDR_WIDTH:0]   o_Words_Loaded
);
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [16:0] DEPTH = 17'(2**ADDR_WIDTH);
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
  state_t state, state_n;
  logic armed;
  logic [7:0] len_lo, sum;
  logic [ADDR_WIDTH:0] len;
  logic [1:0] byte_idx;
  logic [23:0] buffer;
  logic [15:0] n_len;
  logic xfer, last_word;
  assign n_len = {i_Rx_Data, len_lo};
  assign o_Rx_Ready = armed & (state != DONE) & (state != ERROR);
  assign xfer = i_Rx_Valid & o_Rx_Ready;
  assign last_word = (byte_idx == 2'd3) && (o_Words_Loaded + 1'b1 == len);
  assign o_Done = state == DONE;
  assign o_Error = state == ERROR;
  assign o_Core_Reset = ~o_Done;
  always_comb begin
    state_n = state;
    if (xfer)
      case (state)
        LEN_LO:  state_n = LEN_HI;
        LEN_HI:  state_n = {1'b0, n_len} > DEPTH ? ERROR : n_len == 16'd0 ? CHECK : DATA;
        DATA:    state_n = last_word ? CHECK : DATA;
        CHECK:   state_n = 8'(sum + i_Rx_Data) == 8'd0 ? DONE : ERROR;
        default: state_n = state;
      endcase
  end
  always_ff @(posedge i_Clk)
    if (!i_Reset) state <= LEN_LO;
    else state <= state_n;
  always_ff @(posedge i_Clk)
    if (!i_Reset) begin
      armed          <= 1'b0;
      len_lo         <= '0;
      len            <= '0;
      sum            <= '0;
      byte_idx       <= '0;
      buffer         <= '0;
      o_IMem_WE      <= 1'b0;
      o_IMem_Addr    <= '0;
      o_IMem_WData   <= '0;
      o_Words_Loaded <= '0;
    end else begin
      armed     <= 1'b1;
      o_IMem_WE <= 1'b0;
      if (xfer && state == LEN_LO) len_lo <= i_Rx_Data;
      if (xfer && state == LEN_HI) len <= LW'({1'b0, n_len});
      if (xfer && state == DATA) begin
        sum      <= sum + i_Rx_Data;
        byte_idx <= byte_idx + 1'b1;
        buffer   <= {i_Rx_Data, buffer[23:8]};
        if (byte_idx == 2'd3) begin
          o_IMem_WE      <= 1'b1;
          o_IMem_WData   <= {i_Rx_Data, buffer};
          o_IMem_Addr    <= o_Words_Loaded[ADDR_WIDTH-1:0];
          o_Words_Loaded <= o_Words_Loaded + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
  logic i_Clk = 0, i_Reset = 0, i_Rx_Valid = 0;
  logic [7:0] i_Rx_Data = 0;
  logic o_Rx_Ready, o_IMem_WE, o_Core_Reset, o_Done, o_Error;
  logic [7:0] o_IMem_Addr;
  logic [31:0] o_IMem_WData;
  logic [8:0] o_Words_Loaded;
  imem_boot_loader #(.ADDR_WIDTH(8)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Rx_Valid(i_Rx_Valid), .i_Rx_Data(i_Rx_Data),
    .o_Rx_Ready(o_Rx_Ready), .o_IMem_WE(o_IMem_WE), .o_IMem_Addr(o_IMem_Addr),
    .o_IMem_WData(o_IMem_WData), .o_Core_Reset(o_Core_Reset), .o_Done(o_Done),
    .o_Error(o_Error), .o_Words_Loaded(o_Words_Loaded)
  );
  always #5 i_Clk = ~i_Clk;
  typedef struct packed {logic [7:0] addr; logic [31:0] data;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  logic [7:0] stream[$];
  logic [31:0] words[$];
  int tests = 0, fails = 0;
  bit mon_on = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge i_Clk) if (mon_on) begin
    if (o_IMem_WE) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: addr %h data %h, no write expected", o_IMem_Addr, o_IMem_WData);
      end else begin
        mon_e = exp_q.pop_front();
        chk("we_addr", {24'b0, o_IMem_Addr}, {24'b0, mon_e.addr});
        chk("we_data", o_IMem_WData, mon_e.data);
      end
    end
    chk("core_reset_eq_not_done", {31'b0, o_Core_Reset}, {31'b0, !o_Done});
    chk("done_error_exclusive", {31'b0, o_Done & o_Error}, 32'd0);
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic image(input logic [15:0] n, input logic [8:0] c_force, input int push_cnt);
    logic [7:0] s, b;
    s = 0;
    stream = {n[7:0], n[15:8]};
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        stream.push_back(b);
        s = s + b;
      end
      if (i < push_cnt) exp_q.push_back({8'(i), words[i]});
    end
    stream.push_back(c_force[8] ? c_force[7:0] : 8'(8'd0 - s));
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      i_Rx_Valid = 0;
      i_Rx_Data = 8'($urandom);
      @(negedge i_Clk);
    end
    i_Rx_Valid = 1;
    i_Rx_Data = b;
    t = 0;
    while (!o_Rx_Ready && t < 20) begin
      @(negedge i_Clk);
      t++;
    end
    if (t == 20) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: byte %h not accepted within 20 cycles", b);
    end
    @(negedge i_Clk);
    i_Rx_Valid = 0;
    i_Rx_Data = 8'($urandom);
  endtask
  task automatic send_stream(input int maxgap, input int first, input int count);
    for (int i = first; i < first + count; i++)
      send(stream[i], maxgap > 0 ? int'($urandom_range(maxgap)) : 0);
  endtask
  task automatic check_reset_state();
    chk("rst_ready", {31'b0, o_Rx_Ready}, 0);
    chk("rst_we", {31'b0, o_IMem_WE}, 0);
    chk("rst_addr", {24'b0, o_IMem_Addr}, 0);
    chk("rst_wdata", o_IMem_WData, 0);
    chk("rst_core_reset", {31'b0, o_Core_Reset}, 1);
    chk("rst_done", {31'b0, o_Done}, 0);
    chk("rst_error", {31'b0, o_Error}, 0);
    chk("rst_words", {23'b0, o_Words_Loaded}, 0);
  endtask
  task automatic do_reset();
    i_Reset = 0;
    i_Rx_Valid = 0;
    @(negedge i_Clk);
    check_reset_state();
    chk("rst_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    mon_on = 1;
    i_Reset = 1;
    chk("ready_low_at_release", {31'b0, o_Rx_Ready}, 0);
    @(negedge i_Clk);
    chk("ready_after_release", {31'b0, o_Rx_Ready}, 1);
  endtask
  task automatic end_check(input bit done, input bit err, input int wl);
    repeat (3) @(negedge i_Clk);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_done", {31'b0, o_Done}, {31'b0, done});
    chk("end_error", {31'b0, o_Error}, {31'b0, err});
    chk("end_core_reset", {31'b0, o_Core_Reset}, {31'b0, !done});
    chk("end_ready", {31'b0, o_Rx_Ready}, 0);
    chk("end_words", {23'b0, o_Words_Loaded}, wl);
  endtask
  initial begin
    @(negedge i_Clk);
    do_reset();
    words = {32'h00100513, 32'h00200593};
    image(16'd2, 9'h000, 2);
    chk("two_word_checksum", {24'b0, stream[10]}, 32'h20);
    send_stream(0, 0, 10);
    chk("core_reset_before_c", {31'b0, o_Core_Reset}, 1);
    send(stream[10], 0);
    chk("core_reset_after_c", {31'b0, o_Core_Reset}, 0);
    chk("done_after_c", {31'b0, o_Done}, 1);
    end_check(1, 0, 2);
    do_reset();
    image(16'd2, 9'h100, 2);
    send_stream(0, 0, 11);
    end_check(0, 1, 2);
    do_reset();
    words = {};
    image(16'd0, 9'h000, 0);
    send_stream(0, 0, 3);
    end_check(1, 0, 0);
    do_reset();
    image(16'd0, 9'h101, 0);
    send_stream(0, 0, 3);
    end_check(0, 1, 0);
    do_reset();
    stream = {8'h01, 8'h01};
    send_stream(0, 0, 2);
    chk("overflow_error_now", {31'b0, o_Error}, 1);
    chk("overflow_ready_low", {31'b0, o_Rx_Ready}, 0);
    end_check(0, 1, 0);
    do_reset();
    words = {};
    for (int i = 0; i < 256; i++) words.push_back({8'hA5, 8'(i * 3), 8'(i + 1), 8'(i)});
    image(16'd256, 9'h000, 256);
    send_stream(0, 0, stream.size());
    end_check(1, 0, 256);
    do_reset();
    words = {32'h00100513, 32'h00200593};
    image(16'd2, 9'h000, 2);
    send_stream(3, 0, 11);
    end_check(1, 0, 2);
    do_reset();
    image(16'd2, 9'h000, 1);
    send_stream(0, 0, 8);
    do_reset();
    image(16'd2, 9'h000, 2);
    send_stream(1, 0, 11);
    end_check(1, 0, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
